hvsync_generator: RTL and testbench
===================================

HVSYNC_GENERATOR -- requirements
Module: hvsync_generator

Interface
REQ-001 Parameter H_DISPLAY, default 256, visible pixels per line SHALL be configurable.
REQ-002 Parameter H_BACK, default 23, left border (back porch) in clocks SHALL be configurable.
REQ-003 Parameter H_FRONT, default 7, right border (front porch) in clocks SHALL be configurable.
REQ-004 Parameter H_SYNC, default 23, hsync pulse width in clocks SHALL be configurable.
REQ-005 Parameter V_DISPLAY, default 240, visible lines per frame SHALL be configurable.
REQ-006 Parameter V_TOP, default 5, top border in lines SHALL be configurable.
REQ-007 Parameter V_BOTTOM, default 14, bottom border in lines SHALL be configurable.
REQ-008 Parameter V_SYNC, default 3, vsync pulse width in lines SHALL be configurable.
REQ-009 Port clk, input, 1, pixel clock; one clock; all state SHALL update on its rising edge.
REQ-010 Port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-011 Port hsync, output, 1, registered horizontal sync, active high.
REQ-012 Port vsync, output, 1, registered vertical sync, active high.
REQ-013 Port display_on, output, 1, high when current position is inside the visible area.
REQ-014 Port hpos, output, 9, current horizontal position (registered counter).
REQ-015 Port vpos, output, 9, current vertical position (registered counter).

Function
REQ-016 Derived constants SHALL be: H_MAX = H_DISPLAY+H_BACK+H_FRONT+H_SYNC-1 (308); H_SYNC_START = H_DISPLAY+H_FRONT (263); H_SYNC_END = H_SYNC_START+H_SYNC-1 (285).
REQ-017 Derived constants SHALL be: V_MAX = V_DISPLAY+V_TOP+V_BOTTOM+V_SYNC-1 (261); V_SYNC_START = V_DISPLAY+V_BOTTOM (254); V_SYNC_END = V_SYNC_START+V_SYNC-1 (256).
REQ-018 hpos SHALL increment by 1 each clock; when hpos = H_MAX it SHALL wrap to 0 on the next clock.
REQ-019 vpos SHALL increment by 1 only on clocks where hpos wraps from H_MAX to 0; otherwise hold.
REQ-020 When hpos = H_MAX and vpos = V_MAX, both SHALL become 0 on the next clock (frame wrap).
REQ-021 hpos/vpos SHALL never exceed H_MAX/V_MAX; counters SHALL NOT overflow the 9-bit width with defaults.
REQ-022 hsync SHALL be high exactly in cycles where H_SYNC_START <= hpos <= H_SYNC_END (registered, computed from next hpos, zero lag vs hpos).
REQ-023 vsync SHALL be high exactly in cycles where V_SYNC_START <= vpos <= V_SYNC_END, for all hpos in those lines (registered, zero lag vs vpos).
REQ-024 display_on SHALL be combinational: high iff hpos < H_DISPLAY and vpos < V_DISPLAY.
REQ-025 Frame period SHALL be (H_MAX+1)*(V_MAX+1) clocks = 309*262 = 80958 with defaults.
REQ-026 No glitch outputs: hsync, vsync, hpos, vpos SHALL all be flop outputs.

Reset
REQ-027 While reset = 0, asynchronously: hpos = 0, vpos = 0, hsync = 0, vsync = 0; display_on therefore = 1.
REQ-028 On the first rising clk after reset deasserts, hpos SHALL become 1, vpos remain 0.
REQ-029 Reset asserted mid-frame SHALL immediately return all counters and syncs to reset values; no partial-line state retained.

Verification
REQ-030 Reset, then 308 clocks -> hpos = 308, vpos = 0; one more clock -> hpos = 0, vpos = 1.
REQ-031 Over one line from hpos = 0: hsync high for exactly 23 cycles, first at hpos = 263, last at hpos = 285.
REQ-032 Over one frame: vsync high for exactly 3*309 = 927 cycles, vpos 254..256; next frame starts 80958 clocks after reset release start.
REQ-033 display_on: high at (hpos 255, vpos 239), low at (hpos 256, vpos 0), low at (hpos 0, vpos 240).
REQ-034 At hpos = 308, vpos = 261 -> next clock hpos = 0, vpos = 0, display_on = 1, vsync = 0.
REQ-035 Assert reset asynchronously mid-line (e.g. hpos = 150, vpos = 100, between clock edges) -> hpos, vpos, hsync, vsync read 0 before the next clk edge.

Source files
------------

// File: rtl/hvsync_generator.sv
// Video timing generator: free-running pixel/line counters with registered
// sync pulses and a combinational visible-area flag.
module hvsync_generator #(
    parameter int unsigned H_DISPLAY = 256,
    parameter int unsigned H_BACK    = 23,
    parameter int unsigned H_FRONT   = 7,
    parameter int unsigned H_SYNC    = 23,
    parameter int unsigned V_DISPLAY = 240,
    parameter int unsigned V_TOP     = 5,
    parameter int unsigned V_BOTTOM  = 14,
    parameter int unsigned V_SYNC    = 3
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [8:0] hpos,
    output logic [8:0] vpos
);

    localparam logic [8:0] H_MAX        = 9'(H_DISPLAY + H_BACK + H_FRONT + H_SYNC - 1);
    localparam logic [8:0] H_SYNC_START = 9'(H_DISPLAY + H_FRONT);
    localparam logic [8:0] H_SYNC_END   = 9'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [8:0] V_MAX        = 9'(V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC - 1);
    localparam logic [8:0] V_SYNC_START = 9'(V_DISPLAY + V_BOTTOM);
    localparam logic [8:0] V_SYNC_END   = 9'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
    localparam logic [8:0] H_VISIBLE    = 9'(H_DISPLAY);
    localparam logic [8:0] V_VISIBLE    = 9'(V_DISPLAY);

    logic [8:0] hpos_q, hpos_d;
    logic [8:0] vpos_q, vpos_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;

    // Syncs are decoded from the next counter values so the registered
    // pulses line up with the counters they describe, without a cycle of lag.
    always_comb begin
        hpos_d = hpos_q + 9'd1;
        vpos_d = vpos_q;
        if (hpos_q == H_MAX) begin
            hpos_d = '0;
            vpos_d = (vpos_q == V_MAX) ? '0 : vpos_q + 9'd1;
        end
        hsync_d = (hpos_d >= H_SYNC_START) && (hpos_d <= H_SYNC_END);
        vsync_d = (vpos_d >= V_SYNC_START) && (vpos_d <= V_SYNC_END);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hpos_q  <= '0;
            vpos_q  <= '0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign hpos       = hpos_q;
    assign vpos       = vpos_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign display_on = (hpos_q < H_VISIBLE) && (vpos_q < V_VISIBLE);

endmodule

// File: tb/tb_hvsync_generator.sv
// Bench for hvsync_generator: raster position derived from elapsed clocks,
// checked every cycle, plus literal spot checks and an async mid-line reset.
module tb_hvsync_generator;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       hsync, vsync, display_on;
    logic [8:0] hpos, vpos;

    int n_checks = 0;
    int n_pass   = 0;
    int t        = 0;
    bit chk_en   = 1'b0;

    int hs_count, hs_first, hs_last, vs_count;

    localparam int LINE  = 309;
    localparam int LINES = 262;
    localparam int FRAME = LINE * LINES;

    hvsync_generator #(
        .H_DISPLAY(256), .H_BACK(23), .H_FRONT(7), .H_SYNC(23),
        .V_DISPLAY(240), .V_TOP(5), .V_BOTTOM(14), .V_SYNC(3)
    ) dut (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
        .display_on(display_on), .hpos(hpos), .vpos(vpos)
    );

    always #5 clk = ~clk;

    // Clocks elapsed since reset release.
    always @(posedge clk) t <= reset ? t + 1 : 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: t=%0d got 0x%0h expected 0x%0h", name, t, act, exp);
    endtask

    // Model: position follows directly from elapsed clock count.
    always @(negedge clk) begin
        if (chk_en) begin
            automatic int hp = t % LINE;
            automatic int vp = (t / LINE) % LINES;
            automatic logic ehs = (hp >= 263) && (hp <= 285);
            automatic logic evs = (vp >= 254) && (vp <= 256);
            automatic logic ede = (hp < 256) && (vp < 240);
            check("cycle", {11'd0, hpos, vpos, hsync, vsync, display_on},
                  {11'd0, 9'(hp), 9'(vp), ehs, evs, ede});

            if (t == 1) begin
                hs_count = 0; hs_first = -1; hs_last = -1; vs_count = 0;
                check("first_edge", {hpos, vpos}, {9'd1, 9'd0});
            end
            if (t <= LINE - 1 && hsync) begin
                hs_count++;
                if (hs_first < 0) hs_first = int'(hpos);
                hs_last = int'(hpos);
            end
            if (t <= FRAME && vsync) vs_count++;
            if (t == 256)   check("de_h256_v0", display_on, 1'b0);
            if (t == 308)   check("line_end", {hpos, vpos}, {9'd308, 9'd0});
            if (t == 309) begin
                check("line_wrap", {hpos, vpos}, {9'd0, 9'd1});
                check("hs_count", hs_count, 23);
                check("hs_first", hs_first, 263);
                check("hs_last",  hs_last,  285);
            end
            if (t == 239 * 309 + 255) check("de_h255_v239", display_on, 1'b1);
            if (t == 240 * 309)       check("de_h0_v240",   display_on, 1'b0);
            if (t == 80957) check("frame_end", {hpos, vpos}, {9'd308, 9'd261});
            if (t == 80958) begin
                check("frame_wrap", {hpos, vpos, display_on, vsync}, {9'd0, 9'd0, 1'b1, 1'b0});
                check("vs_count", vs_count, 927);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_pos",  {hpos, vpos}, '0);
        check("rst_sync", {hsync, vsync, display_on}, 3'b001);

        // Release between edges; next rising edge is t=1.
        #1 reset = 1'b1;
        chk_en = 1'b1;
        repeat (FRAME + LINE + 270) @(negedge clk);
        #1;
        check("pre_rst_pos", {hpos, vpos, hsync}, {9'd270, 9'd1, 1'b1});

        // Async reset mid-line while hsync is active.
        chk_en = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("async_rst", {hpos, vpos, hsync, vsync, display_on}, {9'd0, 9'd0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        check("rst_held", {hpos, vpos, hsync, vsync}, '0);

        #1 reset = 1'b1;
        chk_en = 1'b1;
        repeat (400) @(negedge clk);
        #1 chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
